// File: rtl/cpu_core_mc.sv
// cpu_core_mc -- multi-cycle CPU core with request/valid instruction and data
// memory ports, conditional jumps, register-offset addressing and an OUT strobe.
//
// Optional feature: define CORE_RET_STACK_EN to build a circular CALL/RET
// return stack of STACK_DEPTH entries; otherwise CALL and RET behave as NOP.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_imem_req/o_imem_addr         instruction fetch request, address (= PC)
//   i_imem_valid/i_imem_data       fetched 16-bit instruction
//   o_dmem_req/we/addr/wdata       data request (we=1 store, 0 load)
//   i_dmem_valid/i_dmem_rdata      load data valid / store accepted
//   o_out, o_out_valid             output register and one-cycle strobe
//   o_halted                       core stopped by HALT (sticky until reset)
module cpu_core_mc #(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned IMEM_ADDR_WIDTH = 8,
  parameter int unsigned DMEM_ADDR_WIDTH = 8,
  parameter int unsigned STACK_DEPTH     = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  output logic                       o_imem_req,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  input  logic                       i_imem_valid,
  input  logic [15:0]                i_imem_data,
  output logic                       o_dmem_req,
  output logic                       o_dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0]      o_dmem_wdata,
  input  logic                       i_dmem_valid,
  input  logic [DATA_WIDTH-1:0]      i_dmem_rdata,
  output logic [DATA_WIDTH-1:0]      o_out,
  output logic                       o_out_valid,
  output logic                       o_halted
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHIFT, OP_LOAD, OP_STORE,
    OP_MOVE, OP_JUMP, OP_LOADC, OP_OUT, OP_CALL, OP_RET, OP_HALT, OP_NOP
  } op_t;

  state_t                     r_state, w_state_nxt;
  logic [IMEM_ADDR_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [15:0]                r_ir;
  logic [DATA_WIDTH-1:0]      r_regs [4];
  logic [DATA_WIDTH-1:0]      r_out;
  logic                       r_out_valid;

  op_t                   w_op;
  logic [1:0]            w_hi, w_lo;
  logic [7:0]            w_k;
  logic [DATA_WIDTH-1:0] w_kz, w_in1, w_in2, w_rhi;
  logic [SHW-1:0]        w_shamt;
  logic                  w_jmp, w_mem;
  logic                  w_rf_we, w_out_ld;
  logic [DATA_WIDTH-1:0] w_rf_wdata;

  assign w_op     = op_t'(r_ir[15:12]);
  assign w_hi     = r_ir[11:10];
  assign w_lo     = r_ir[9:8];
  assign w_k      = r_ir[7:0];
  assign w_kz     = DATA_WIDTH'(w_k);
  assign w_in1    = w_lo[1] ? r_regs[2] : r_regs[0];
  assign w_in2    = w_lo[0] ? w_kz : r_regs[1];
  assign w_rhi    = r_regs[w_hi];
  assign w_shamt  = SHW'(w_lo[1] ? w_kz : r_regs[1]);
  assign w_pc_inc = r_pc + 1'b1;

  always_comb begin
    w_jmp = 1'b0;
    case (w_lo)
      2'b00: w_jmp = 1'b1;
      2'b01: w_jmp = (r_regs[1] == '0);
      2'b10: w_jmp = (r_regs[1] != '0);
      2'b11: w_jmp = r_regs[1][DATA_WIDTH-1];
      default: w_jmp = 1'b0;
    endcase
  end

`ifdef CORE_RET_STACK_EN
  localparam int unsigned SPW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int unsigned CNW = $clog2(STACK_DEPTH + 1);

  logic [IMEM_ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [SPW-1:0]             r_sp;   // next slot to write
  logic [CNW-1:0]             r_cnt;
  logic [SPW-1:0]             w_sp_inc, w_sp_dec;
  logic                       w_push, w_pop;

  assign w_sp_inc = (r_sp == SPW'(STACK_DEPTH - 1)) ? '0 : r_sp + 1'b1;
  assign w_sp_dec = (r_sp == '0) ? SPW'(STACK_DEPTH - 1) : r_sp - 1'b1;

  // A push on a full stack overwrites the oldest slot; count saturates.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp  <= '0;
      r_cnt <= '0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (w_push) begin
      r_stack[r_sp] <= w_pc_inc;
      r_sp          <= w_sp_inc;
      if (r_cnt != CNW'(STACK_DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (w_pop && (r_cnt != '0)) begin
      r_sp  <= w_sp_dec;
      r_cnt <= r_cnt - 1'b1;
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rf_we     = 1'b0;
    w_rf_wdata  = '0;
    w_out_ld    = 1'b0;
`ifdef CORE_RET_STACK_EN
    w_push      = 1'b0;
    w_pop       = 1'b0;
`endif
    unique case (r_state)
      S_FETCH: if (i_imem_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        case (w_op)
          OP_ADD:   begin w_rf_we = 1'b1; w_rf_wdata = w_in1 + w_in2; end
          OP_SUB:   begin w_rf_we = 1'b1; w_rf_wdata = w_in1 - w_in2; end
          OP_AND:   begin w_rf_we = 1'b1; w_rf_wdata = w_in1 & w_in2; end
          OP_OR:    begin w_rf_we = 1'b1; w_rf_wdata = w_in1 | w_in2; end
          OP_XOR:   begin w_rf_we = 1'b1; w_rf_wdata = w_in1 ^ w_in2; end
          OP_SHIFT: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = w_lo[0] ? (w_rhi >> w_shamt) : (w_rhi << w_shamt);
          end
          OP_LOAD, OP_STORE: begin
            w_state_nxt = S_MEM;
            w_pc_nxt    = r_pc;
          end
          OP_MOVE:  begin w_rf_we = 1'b1; w_rf_wdata = r_regs[w_lo]; end
          OP_JUMP:  if (w_jmp) w_pc_nxt = IMEM_ADDR_WIDTH'(r_regs[0]);
          OP_LOADC: begin
            w_rf_we = 1'b1;
            if (w_lo[1]) begin
              w_rf_wdata       = w_rhi;
              w_rf_wdata[15:8] = w_k;
            end else begin
              w_rf_wdata = w_kz;
            end
          end
          OP_OUT:   w_out_ld = 1'b1;
`ifdef CORE_RET_STACK_EN
          OP_CALL: begin
            w_push   = 1'b1;
            w_pc_nxt = IMEM_ADDR_WIDTH'(r_regs[0]);
          end
          OP_RET: begin
            w_pop    = 1'b1;
            w_pc_nxt = (r_cnt == '0) ? '0 : r_stack[w_sp_dec];
          end
`endif
          OP_HALT: begin
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
          end
          default: ;
        endcase
      end
      S_MEM: if (i_dmem_valid) begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        if (w_op == OP_LOAD) begin
          w_rf_we    = 1'b1;
          w_rf_wdata = i_dmem_rdata;
        end
      end
      S_HALT: ;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc        <= '0;
      r_ir        <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_out_valid <= w_out_ld;
      if (r_state == S_FETCH && i_imem_valid) r_ir <= i_imem_data;
      if (w_rf_we) r_regs[w_hi] <= w_rf_wdata;
      if (w_out_ld) r_out <= w_rhi;
    end
  end

  // Requests are gated by reset so they drop the moment reset asserts,
  // even though the state register already reads FETCH.
  assign w_mem        = i_rst_n && (r_state == S_MEM);
  assign o_imem_req   = i_rst_n && (r_state == S_FETCH);
  assign o_imem_addr  = r_pc;
  assign o_dmem_req   = w_mem;
  assign o_dmem_we    = w_mem && (w_op == OP_STORE);
  assign o_dmem_addr  = w_mem ? DMEM_ADDR_WIDTH'(w_lo[0] ? (r_regs[1] + w_kz) : w_kz) : '0;
  assign o_dmem_wdata = w_mem ? w_rhi : '0;
  assign o_out        = r_out;
  assign o_out_valid  = r_out_valid;
  assign o_halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_core_mc.sv
module tb_cpu_core_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req, i_imem_valid;
  logic [7:0]  o_imem_addr;
  logic [15:0] i_imem_data;
  logic        o_dmem_req, o_dmem_we, i_dmem_valid;
  logic [7:0]  o_dmem_addr;
  logic [15:0] o_dmem_wdata, i_dmem_rdata, o_out;
  logic        o_out_valid, o_halted;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int          iwait = 0;
  int          dwait = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [7:0]  q_fetch [$];
  logic [15:0] q_out   [$];
  logic [24:0] q_dmem  [$];   // {we, addr, wdata}

  cpu_core_mc #(
    .DATA_WIDTH(16), .IMEM_ADDR_WIDTH(8), .DMEM_ADDR_WIDTH(8), .STACK_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_valid(i_imem_valid), .i_imem_data(i_imem_data),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_valid(i_dmem_valid), .i_dmem_rdata(i_dmem_rdata),
    .o_out(o_out), .o_out_valid(o_out_valid), .o_halted(o_halted)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic extra(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected 0x%0h, expected nothing", name, act);
  endtask

  // Instruction memory with iwait wait cycles per fetch.
  initial begin : imem_rsp
    int cnt;
    cnt = 0;
    i_imem_valid = 1'b0;
    i_imem_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && o_imem_req) begin
        if (cnt >= iwait) begin
          i_imem_valid = 1'b1;
          i_imem_data  = imem[o_imem_addr];
          cnt = 0;
        end else begin
          i_imem_valid = 1'b0;
          cnt++;
        end
      end else begin
        i_imem_valid = 1'b0;
        cnt = 0;
      end
    end
  end

  // Data memory with dwait wait cycles per access.
  initial begin : dmem_rsp
    int cnt;
    cnt = 0;
    i_dmem_valid = 1'b0;
    i_dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && o_dmem_req) begin
        if (cnt >= dwait) begin
          i_dmem_valid = 1'b1;
          if (o_dmem_we) dmem[o_dmem_addr] = o_dmem_wdata;
          else           i_dmem_rdata = dmem[o_dmem_addr];
          cnt = 0;
        end else begin
          i_dmem_valid = 1'b0;
          cnt++;
        end
      end else begin
        i_dmem_valid = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: pops expected fetches, data transactions and OUT values.
  initial begin : monitor
    logic [7:0]  prev_addr;
    logic        prev_wait;
    logic [24:0] e;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n !== 1'b1) begin
        prev_wait = 1'b0;
      end else begin
        if (o_imem_req) begin
          if (prev_wait) chk("imem_addr_stable", 32'(o_imem_addr), 32'(prev_addr));
          if (i_imem_valid) begin
            if (q_fetch.size() == 0) extra("fetch", 32'(o_imem_addr));
            else chk("fetch_addr", 32'(o_imem_addr), 32'(q_fetch.pop_front()));
            prev_wait = 1'b0;
          end else begin
            prev_wait = 1'b1;
            prev_addr = o_imem_addr;
          end
        end else begin
          prev_wait = 1'b0;
        end
        if (o_dmem_req && i_dmem_valid) begin
          if (q_dmem.size() == 0) extra("dmem_txn", 32'(o_dmem_addr));
          else begin
            e = q_dmem.pop_front();
            chk("dmem_we", 32'(o_dmem_we), 32'(e[24]));
            chk("dmem_addr", 32'(o_dmem_addr), 32'(e[23:16]));
            if (e[24]) chk("dmem_wdata", 32'(o_dmem_wdata), 32'(e[15:0]));
          end
        end
        if (o_out_valid) begin
          if (q_out.size() == 0) extra("out_strobe", 32'(o_out));
          else chk("out_value", 32'(o_out), 32'(q_out.pop_front()));
        end
      end
    end
  end

  task automatic hold_reset();
    rst_n = 1'b0;
    q_fetch.delete();
    q_out.delete();
    q_dmem.delete();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'hE000;
      dmem[i] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_imem_req", 32'(o_imem_req), 32'd0);
    chk("rst_pc", 32'(o_imem_addr), 32'd0);
    chk("rst_dmem_req", 32'(o_dmem_req), 32'd0);
    chk("rst_out", 32'(o_out), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic push_fetch(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) q_fetch.push_back(8'(a));
  endtask

  task automatic run_prog(input string tag, input int exp_cycles);
    int cyc;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (o_halted) break;
      cyc++;
    end
    if (!o_halted) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: halted=%0b after %0d cycles, expected 1", tag, o_halted, cyc);
    end else begin
      if (exp_cycles >= 0) chk({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles));
      repeat (6) @(negedge clk);
      #1;
      chk({tag, "_halted"}, 32'(o_halted), 32'd1);
      chk({tag, "_no_fetch"}, 32'(o_imem_req), 32'd0);
      chk({tag, "_no_dmem"}, 32'(o_dmem_req), 32'd0);
      chk({tag, "_fetch_left"}, 32'(q_fetch.size()), 32'd0);
      chk({tag, "_out_left"}, 32'(q_out.size()), 32'd0);
      chk({tag, "_dmem_left"}, 32'(q_dmem.size()), 32'd0);
    end
  endtask

  task automatic load_prog1();
    imem[0] = 16'hA005;   // LOADC r0,5
    imem[1] = 16'hA403;   // LOADC r1,3
    imem[2] = 16'h0000;   // ADD r0 = r0 + r1
    imem[3] = 16'hB000;   // OUT r0
    imem[4] = 16'hE000;   // HALT
  endtask

  task automatic load_prog2();
    imem[0]  = 16'hA034;  // LOADC r0,0x34
    imem[1]  = 16'hA212;  // LOADC r0.hi,0x12 -> 0x1234
    imem[2]  = 16'hA402;  // LOADC r1,2
    imem[3]  = 16'h7110;  // STORE r0 -> [r1+0x10]
    imem[4]  = 16'h6910;  // LOAD r2 <- [r1+0x10]
    imem[5]  = 16'hB800;  // OUT r2
    imem[6]  = 16'h1D34;  // SUB r3 = r0 - 0x34
    imem[7]  = 16'hBC00;
    imem[8]  = 16'h4E00;  // XOR r3 = r2 ^ r1
    imem[9]  = 16'hBC00;
    imem[10] = 16'h5F04;  // SHIFT r3 >> 4
    imem[11] = 16'hBC00;
    imem[12] = 16'h5C00;  // SHIFT r3 << r1
    imem[13] = 16'hBC00;
    imem[14] = 16'hA001;  // LOADC r0,1
    imem[15] = 16'h1D02;  // SUB r3 = r0 - 2 (wraps)
    imem[16] = 16'hBC00;
    imem[17] = 16'h8700;  // MOVE r1 <- r3
    imem[18] = 16'h2800;  // AND r2 = r0 & r1
    imem[19] = 16'h3BF0;  // OR r2 = r2 | 0xF0
    imem[20] = 16'hB800;
    imem[21] = 16'hE000;
  endtask

  initial begin : stim
    rst_n = 1'b0;

    // Basic program, zero-wait fetch: 4 two-cycle instructions plus HALT.
    hold_reset();
    load_prog1();
    push_fetch(0, 4);
    q_out.push_back(16'd8);
    release_reset();
    run_prog("p1", 10);

    // Same program with 3 fetch wait cycles.
    iwait = 3;
    hold_reset();
    load_prog1();
    push_fetch(0, 4);
    q_out.push_back(16'd8);
    release_reset();
    run_prog("p1_wait", 25);
    iwait = 0;

    // ALU, shifts, register-offset store/load.
    dwait = 1;
    hold_reset();
    load_prog2();
    push_fetch(0, 21);
    q_dmem.push_back({1'b1, 8'h12, 16'h1234});
    q_dmem.push_back({1'b0, 8'h12, 16'h0000});
    q_out.push_back(16'h1234);
    q_out.push_back(16'h1200);
    q_out.push_back(16'h1236);
    q_out.push_back(16'h0123);
    q_out.push_back(16'h048C);
    q_out.push_back(16'hFFFF);
    q_out.push_back(16'h00F1);
    release_reset();
    run_prog("p2", -1);
    dwait = 0;

    // Conditional jumps and PC wrap at 0xFF.
    hold_reset();
    imem[8'h00] = 16'h9300; imem[8'h01] = 16'hA010; imem[8'h02] = 16'hA400;
    imem[8'h03] = 16'h9100;
    imem[8'h10] = 16'hA401; imem[8'h11] = 16'h9100; imem[8'h12] = 16'hA020;
    imem[8'h13] = 16'h9200;
    imem[8'h20] = 16'h9300; imem[8'h21] = 16'hA680; imem[8'h22] = 16'hA0FE;
    imem[8'h23] = 16'h9300;
    imem[8'hFE] = 16'hA030; imem[8'hFF] = 16'hF000;
    push_fetch(8'h00, 8'h03);
    push_fetch(8'h10, 8'h13);
    push_fetch(8'h20, 8'h23);
    push_fetch(8'hFE, 8'hFF);
    q_fetch.push_back(8'h00);
`ifdef CORE_RET_STACK_EN
    imem[8'h30] = 16'hB400; imem[8'h31] = 16'hE000;
    push_fetch(8'h30, 8'h31);
`else
    // CALL and RET fall through as NOP in this build.
    imem[8'h30] = 16'hC000; imem[8'h31] = 16'hD000;
    imem[8'h32] = 16'hB400; imem[8'h33] = 16'hE000;
    push_fetch(8'h30, 8'h33);
`endif
    q_out.push_back(16'h8001);
    release_reset();
    run_prog("p3", -1);

`ifdef CORE_RET_STACK_EN
    // CALL from 0x10 to 0x40, RET to 0x11, RET on empty stack to 0.
    hold_reset();
    imem[8'h00] = 16'h9300; imem[8'h01] = 16'hA00F; imem[8'h02] = 16'h9000;
    imem[8'h0F] = 16'hA040; imem[8'h10] = 16'hC000;
    imem[8'h40] = 16'hD000;
    imem[8'h11] = 16'hA680; imem[8'h12] = 16'hA050; imem[8'h13] = 16'hD000;
    imem[8'h50] = 16'hB400; imem[8'h51] = 16'hE000;
    push_fetch(8'h00, 8'h02);
    push_fetch(8'h0F, 8'h10);
    q_fetch.push_back(8'h40);
    push_fetch(8'h11, 8'h13);
    q_fetch.push_back(8'h00);
    push_fetch(8'h50, 8'h51);
    q_out.push_back(16'h8000);
    release_reset();
    run_prog("stack", -1);
`endif

    // Reset asserted while a store waits in MEM.
    dwait = 5;
    hold_reset();
    load_prog2();
    push_fetch(0, 3);
    q_dmem.push_back({1'b1, 8'h12, 16'h1234});
    release_reset();
    for (int i = 0; i < 200 && !o_dmem_req; i++) @(negedge clk);
    chk("mem_wait_reached", 32'(o_dmem_req), 32'd1);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_dmem_req", 32'(o_dmem_req), 32'd0);
    chk("mid_rst_imem_req", 32'(o_imem_req), 32'd0);
    hold_reset();
    dwait = 0;
    imem[0] = 16'hB000; imem[1] = 16'hB400; imem[2] = 16'hB800;
    imem[3] = 16'hBC00; imem[4] = 16'hE000;
    push_fetch(0, 4);
    for (int i = 0; i < 4; i++) q_out.push_back(16'h0000);
    release_reset();
    run_prog("post_rst", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
